inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage for the RV64IFD core. Sits directly upstream of the control unit and drives its 32-bit instruction input.
- Holds the fetch PC and issues single-outstanding word requests to instruction memory.
- Buffers returned instructions and their PCs in a small prefetch FIFO, presented downstream with a valid/ready handshake.
- Accepts redirects (taken branch, JAL/JALR) from the execute stage. A redirect flushes buffered and in-flight instructions.

Parameters:
- PC_WIDTH, 64, width of fetch PC and memory address.
- RESET_PC, 64'h0, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, 2..16).

Ports:
- in_clk  input  1  clock; all state updates on rising edge
- in_rst  input  1  synchronous active-high reset
- out_imem_req  output  1  fetch request valid
- out_imem_addr  output  PC_WIDTH  fetch address, word aligned
- in_imem_ack  input  1  memory accepted request; data valid this cycle
- in_imem_data  input  32  instruction word, valid when in_imem_ack=1
- in_redirect  input  1  redirect fetch (one-cycle pulse)
- in_redirect_pc  input  PC_WIDTH  redirect target
- out_inst  output  32  instruction to control unit
- out_inst_pc  output  PC_WIDTH  PC of out_inst
- out_inst_valid  output  1  out_inst/out_inst_pc valid
- in_inst_ready  input  1  downstream accepts instruction

Behaviour:
- Reset (in_rst=1 sampled on edge): out_imem_req=0, out_imem_addr=RESET_PC, FIFO empty, out_inst_valid=0, out_inst=32'h00000013 (NOP), out_inst_pc=0, state=FETCH, fetch PC=RESET_PC.
  - Reset asserted mid-operation aborts everything. Any ack arriving afterward is ignored.
- States:
  - FETCH: issuing or waiting.
  - DRAIN: a redirect arrived while a request was pending. Wait for its ack, discard the data.
- FETCH:
  - out_imem_req=1 whenever FIFO count < FIFO_DEPTH.
  - Once raised, req and addr are held stable until in_imem_ack.
  - On ack: push {fetch PC, in_imem_data} into the FIFO. Fetch PC += 4 (wraps modulo 2^PC_WIDTH).
  - The next request may issue the cycle after the ack.
- At most one request outstanding. The request is never withdrawn before its ack.
- Ack at edge N with FIFO empty: out_inst_valid=1 in cycle N+1 (1-cycle latency).
- Output: head of FIFO. Pop when out_inst_valid & in_inst_ready.
  - Push and pop in the same cycle are both performed; count unchanged.
  - FIFO full: no request issued; resumes the cycle after a pop.
  - FIFO empty: out_inst=32'h00000013 and out_inst_pc=0.
- Redirect, with target pc = in_redirect_pc with bits [1:0] forced to 0:
  - A pop in the same cycle completes first; then the entire FIFO is flushed.
  - Request pending and not acked: go to DRAIN. Keep req/addr stable, latch target. On ack, discard data. Next cycle, return to FETCH at the target.
  - Ack in same cycle as redirect: data discarded; next request uses the target.
  - No request pending: next request uses the target.
  - Redirect while in DRAIN: replaces the latched target; remain in DRAIN.
- out_inst_valid is 0 on the cycle after any redirect.

Optional Feature:
- Macro IFU_BYPASS_EN.
- Defined: when FIFO is empty and in_imem_ack=1 in FETCH (no redirect), out_inst/out_inst_pc/out_inst_valid are driven combinationally from in_imem_data/fetch PC in the ack cycle (0-cycle latency).
  - If in_inst_ready=1 the word is consumed and not written to the FIFO; otherwise it is pushed.
- Not defined: all returned words pass through the FIFO; 1-cycle latency as above.

Test Plan:
- Reset, memory acks every request after 1 cycle, ready=1 -> addresses 0x0,0x4,0x8,...; out_inst_pc follows each ack by 1 cycle with matching data.
- ready=0 with FIFO_DEPTH=4 -> exactly 4 acks, then out_imem_req=0. Raise ready for one cycle -> one pop, request reissued next cycle at 0x10.
- Redirect to 0x1002 while request at 0x8 pending, ack 3 cycles later -> addr held 0x8 until ack, data dropped, next request at 0x1000. No 0x8 instruction is output.
- Redirect coincident with ack and with a pop -> popped instruction consumed once, acked data dropped, FIFO empty, next addr = target.
- Fetch PC 0xFFFF_FFFF_FFFF_FFFC acked -> next request at 0x0.
- IFU_BYPASS_EN defined, FIFO empty, ack with ready=1 -> out_inst_valid in the same cycle and FIFO count stays 0. Without the macro -> valid one cycle later.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage. Holds the fetch PC, issues at most one outstanding
// word request to instruction memory, and buffers returned words with their
// PCs in a small prefetch FIFO. The FIFO head goes downstream to the control
// unit under a valid/ready handshake. A redirect from execute flushes the
// FIFO. If a request is still outstanding at that point, the unit waits for
// the request's ack in DRAIN and drops the returned word.
//
// Optional build macro:
//   IFU_BYPASS_EN - when the FIFO is empty, an acked word is shown on the
//                   output in the same cycle as its ack (0-cycle latency).
//                   If the word is consumed in that cycle, it is not
//                   written to the FIFO.
//
// Ports:
//   in_clk, in_rst           clock, synchronous active-high reset
//   out_imem_req/addr        fetch request and word-aligned address
//   in_imem_ack/data         request accepted; instruction word valid
//   in_redirect/redirect_pc  one-cycle redirect pulse and its target
//   out_inst/inst_pc/valid   FIFO head to control unit (NOP/0 when empty)
//   in_inst_ready            downstream accepts out_inst
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int unsigned         PC_WIDTH   = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         FIFO_DEPTH = 4
) (
  input  logic                in_clk,
  input  logic                in_rst,
  output logic                out_imem_req,
  output logic [PC_WIDTH-1:0] out_imem_addr,
  input  logic                in_imem_ack,
  input  logic [31:0]         in_imem_data,
  input  logic                in_redirect,
  input  logic [PC_WIDTH-1:0] in_redirect_pc,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_inst_pc,
  output logic                out_inst_valid,
  input  logic                in_inst_ready
);

  localparam int unsigned   PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CntW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [31:0]   Nop      = 32'h0000_0013;

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic                req_q, req_d;
  logic                redir_q;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic [31:0]         inst_mem [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [FIFO_DEPTH];

  logic [PC_WIDTH-1:0] target;
  logic                ack;
  logic                ack_fetch;
  logic                fifo_empty;
  logic                bypass;
  logic                fifo_push;
  logic                fifo_pop;

  // Redirect targets are forced to a word boundary.
  assign target     = in_redirect_pc & ~PC_WIDTH'(3);
  // Acks count only against a request that is actually outstanding.
  // This drops stray acks that arrive after a reset.
  assign ack        = req_q & in_imem_ack;
  assign ack_fetch  = ack & (state_q == StFetch) & ~in_redirect;
  assign fifo_empty = (count_q == '0);

`ifdef IFU_BYPASS_EN
  // Suppressed in the cycle after a redirect so valid stays low there.
  assign bypass = fifo_empty & ack_fetch & ~redir_q;
`else
  assign bypass = 1'b0;
`endif

  assign out_imem_req  = req_q;
  assign out_imem_addr = pc_q;

  always_comb begin
    out_inst       = Nop;
    out_inst_pc    = '0;
    out_inst_valid = 1'b0;
    if (bypass) begin
      out_inst       = in_imem_data;
      out_inst_pc    = pc_q;
      out_inst_valid = 1'b1;
    end else if (!fifo_empty) begin
      out_inst       = inst_mem[rd_ptr_q];
      out_inst_pc    = pc_mem[rd_ptr_q];
      out_inst_valid = 1'b1;
    end
  end

  assign fifo_pop  = ~fifo_empty & out_inst_valid & in_inst_ready;
  // A bypassed word consumed in its ack cycle never enters the FIFO.
  assign fifo_push = ack_fetch & ~(bypass & in_inst_ready);

  // FIFO pointers and occupancy. A redirect flushes after any same-cycle pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (in_redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({fifo_push, fifo_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM and fetch PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      StFetch: begin
        if (in_redirect) begin
          if (req_q && !in_imem_ack) begin
            // The outstanding request must complete before fetch moves to the target.
            state_d = StDrain;
            tgt_d   = target;
          end else begin
            pc_d = target;
          end
        end else if (ack) begin
          pc_d = pc_q + PC_WIDTH'(4);
        end
      end
      StDrain: begin
        if (in_redirect) tgt_d = target;
        if (ack) begin
          state_d = StFetch;
          pc_d    = in_redirect ? target : tgt_q;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // A raised request stays up until it is acked. After the ack, a new
  // request issues if there is room in the FIFO.
  always_comb begin
    if (req_q && !in_imem_ack) begin
      req_d = 1'b1;
    end else begin
      req_d = (state_d == StFetch) && (count_d < DepthCnt);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      tgt_q    <= RESET_PC;
      req_q    <= 1'b0;
      redir_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      req_q    <= req_d;
      redir_q  <= in_redirect;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset. The occupancy count qualifies every read.
  always_ff @(posedge in_clk) begin
    if (fifo_push) begin
      inst_mem[wr_ptr_q] <= in_imem_data;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit with its default parameters.
// Inputs are driven and registered outputs are sampled 1 ns after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

`ifdef IFU_BYPASS_EN
  localparam logic Bypass = 1'b1;
`else
  localparam logic Bypass = 1'b0;
`endif

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        out_imem_req;
  logic [63:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_data;
  logic        in_redirect;
  logic [63:0] in_redirect_pc;
  logic [31:0] out_inst;
  logic [63:0] out_inst_pc;
  logic        out_inst_valid;
  logic        in_inst_ready;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_unit dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .out_imem_req   (out_imem_req),
    .out_imem_addr  (out_imem_addr),
    .in_imem_ack    (in_imem_ack),
    .in_imem_data   (in_imem_data),
    .in_redirect    (in_redirect),
    .in_redirect_pc (in_redirect_pc),
    .out_inst       (out_inst),
    .out_inst_pc    (out_inst_pc),
    .out_inst_valid (out_inst_valid),
    .in_inst_ready  (in_inst_ready)
  );

  always #5 in_clk = ~in_clk;

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC000_0000 ^ a[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst         = 1'b1;
    in_imem_ack    = 1'b0;
    in_imem_data   = '0;
    in_redirect    = 1'b0;
    in_redirect_pc = '0;
    in_inst_ready  = 1'b0;
    step();
    step();
    in_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;

    // Reset state.
    do_reset();
    check_eq("rst_req",   out_imem_req,   0);
    check_eq("rst_addr",  out_imem_addr,  0);
    check_eq("rst_valid", out_inst_valid, 0);
    check_eq("rst_inst",  out_inst,       64'h13);
    check_eq("rst_pc",    out_inst_pc,    0);

    // Streaming: every request acked, downstream always ready.
    step();
    in_inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_eq("str_req",   out_imem_req,   1);
      check_eq("str_addr",  out_imem_addr,  64'(4 * k));
      check_eq("str_valid", out_inst_valid, 64'(k > 0));
      if (k > 0) begin
        check_eq("str_pc",   out_inst_pc, 64'(4 * (k - 1)));
        check_eq("str_inst", out_inst,    64'(mem_word(64'(4 * (k - 1)))));
      end
      in_imem_ack  = 1'b1;
      in_imem_data = mem_word(64'(4 * k));
      step();
    end
    in_imem_ack = 1'b0;

    // Fill the FIFO with ready low, then make room with a single pop.
    do_reset();
    step();
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_imem_req) begin
        in_imem_ack  = 1'b1;
        in_imem_data = mem_word(out_imem_addr);
        acks++;
      end else begin
        in_imem_ack = 1'b0;
      end
      step();
    end
    in_imem_ack = 1'b0;
    check_eq("full_acks",  64'(acks),      4);
    check_eq("full_req",   out_imem_req,   0);
    check_eq("full_valid", out_inst_valid, 1);
    check_eq("full_pc",    out_inst_pc,    0);
    check_eq("full_inst",  out_inst,       64'(mem_word(0)));
    in_inst_ready = 1'b1;
    step();
    in_inst_ready = 1'b0;
    check_eq("pop_req",  out_imem_req,  1);
    check_eq("pop_addr", out_imem_addr, 64'h10);
    check_eq("pop_head", out_inst_pc,   4);
    step();
    check_eq("hold_req",  out_imem_req,  1);
    check_eq("hold_addr", out_imem_addr, 64'h10);

    // Redirect while the request at 0x8 is pending; ack three cycles later.
    do_reset();
    step();
    in_inst_ready = 1'b1;
    in_imem_ack   = 1'b1;
    in_imem_data  = mem_word(0);
    step();
    in_imem_data  = mem_word(4);
    step();
    check_eq("drn_addr0", out_imem_addr, 8);
    check_eq("drn_pc0",   out_inst_pc,   4);
    in_imem_ack    = 1'b0;
    in_redirect    = 1'b1;
    in_redirect_pc = 64'h1002;
    step();
    in_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("drn_req",   out_imem_req,   1);
      check_eq("drn_addr",  out_imem_addr,  8);
      check_eq("drn_valid", out_inst_valid, 0);
      if (i == 2) begin
        in_imem_ack  = 1'b1;
        in_imem_data = mem_word(8);
      end
      step();
    end
    in_imem_ack = 1'b0;
    check_eq("drn_tgt_req",   out_imem_req,   1);
    check_eq("drn_tgt_addr",  out_imem_addr,  64'h1000);
    check_eq("drn_tgt_valid", out_inst_valid, 0);
    in_imem_ack  = 1'b1;
    in_imem_data = mem_word(64'h1000);
    step();
    in_imem_ack = 1'b0;
    check_eq("drn_out_valid", out_inst_valid, 1);
    check_eq("drn_out_pc",    out_inst_pc,    64'h1000);
    check_eq("drn_out_inst",  out_inst,       64'(mem_word(64'h1000)));

    // Redirect coincident with an ack and a pop.
    do_reset();
    step();
    in_imem_ack  = 1'b1;
    in_imem_data = mem_word(0);
    step();
    in_imem_data = mem_word(4);
    step();
    check_eq("co_valid0", out_inst_valid, 1);
    check_eq("co_pc0",    out_inst_pc,    0);
    in_inst_ready  = 1'b1;
    in_imem_data   = mem_word(8);
    in_redirect    = 1'b1;
    in_redirect_pc = 64'h2000;
    step();
    in_redirect = 1'b0;
    check_eq("co_valid", out_inst_valid, 0);
    check_eq("co_inst",  out_inst,       64'h13);
    check_eq("co_pc",    out_inst_pc,    0);
    check_eq("co_req",   out_imem_req,   1);
    check_eq("co_addr",  out_imem_addr,  64'h2000);
    in_imem_data = mem_word(64'h2000);
    step();
    in_imem_ack = 1'b0;
    check_eq("co_next_pc", out_inst_pc, 64'h2000);

    // Fetch PC wraps to zero after the top word.
    do_reset();
    step();
    in_inst_ready  = 1'b1;
    in_imem_ack    = 1'b1;
    in_imem_data   = mem_word(0);
    in_redirect    = 1'b1;
    in_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    in_redirect = 1'b0;
    check_eq("wrap_addr0",  out_imem_addr,  64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_valid0", out_inst_valid, 0);
    in_imem_data = mem_word(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    in_imem_ack = 1'b0;
    check_eq("wrap_addr",  out_imem_addr, 0);
    check_eq("wrap_req",   out_imem_req,  1);
    check_eq("wrap_pc",    out_inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_inst",  out_inst,      64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));

    // Empty-FIFO ack latency (0 cycles with bypass, 1 cycle without).
    do_reset();
    step();
    in_inst_ready = 1'b1;
    in_imem_ack   = 1'b1;
    in_imem_data  = mem_word(0);
    #1;
    check_eq("lat_ack_cycle", out_inst_valid, 64'(Bypass));
    step();
    in_imem_ack = 1'b0;
    check_eq("lat_next_cycle", out_inst_valid, 64'(!Bypass));

    // Reset mid-request; a stale ack right after reset is ignored.
    in_rst = 1'b1;
    step();
    in_rst       = 1'b0;
    in_imem_ack  = 1'b1;
    in_imem_data = 32'hDEAD_BEEF;
    step();
    in_imem_ack = 1'b0;
    check_eq("stale_addr",  out_imem_addr,  0);
    check_eq("stale_req",   out_imem_req,   1);
    check_eq("stale_valid", out_inst_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
